// File: rtl/standoff_arbiter.sv
// Purpose: two-player standoff round controller (arm, random wait, draw cue, first-press arbitration).
// Latency: press edge seen in cycle p -> result_valid/winner/foul/reaction_time registered at p+1.
// Backpressure: none; buttons are level inputs, start is only honoured in IDLE/DONE.
module standoff_arbiter #(
  parameter int unsigned WAIT_MIN    = 100_000_000,
  parameter int unsigned DELAY_SHIFT = 19,
  parameter int unsigned TIMEOUT     = 300_000_000,
  parameter int unsigned RT_W        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            p0_btn,
  input  logic            p1_btn,
  output logic            busy,
  output logic            draw,
  output logic            result_valid,
  output logic [1:0]      winner,
  output logic [1:0]      foul,
  output logic [RT_W-1:0] reaction_time
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_DRAW,
    S_DONE
  } state_t;

  localparam logic [15:0]     LFSR_SEED  = 16'hACE1;
  localparam logic [RT_W-1:0] ONE        = RT_W'(1);
  localparam logic [RT_W-1:0] WAIT_MIN_V = RT_W'(WAIT_MIN);
  localparam logic [RT_W-1:0] TO_LAST    = RT_W'(TIMEOUT - 1);
  localparam logic [RT_W-1:0] TO_VAL     = RT_W'(TIMEOUT);

  state_t          state_q, state_d;
  logic            p0_prev_q, p0_prev_d;
  logic            p1_prev_q, p1_prev_d;
  logic [15:0]     lfsr_q, lfsr_d;
  // Shared counter: remaining delay in WAIT, elapsed cycles in DRAW.
  logic [RT_W-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            draw_q, draw_d;
  logic            rv_q, rv_d;
  logic [1:0]      winner_q, winner_d;
  logic [1:0]      foul_q, foul_d;
  logic [RT_W-1:0] rt_q, rt_d;

  logic            p0_press, p1_press;
  logic [RT_W-1:0] delay_load;

  // Rising-edge press detect and the random delay derived from the current LFSR state.
  always_comb begin
    p0_press   = p0_btn & ~p0_prev_q;
    p1_press   = p1_btn & ~p1_prev_q;
    delay_load = WAIT_MIN_V + (RT_W'(lfsr_q[7:0]) << DELAY_SHIFT);
  end

  // Next-state, counter and result computation for the round sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    winner_d  = winner_q;
    foul_d    = foul_q;
    rt_d      = rt_q;
    rv_d      = 1'b0;
    p0_prev_d = p0_btn;
    p1_prev_d = p1_btn;
    // Fibonacci taps 16,14,13,11; a non-zero seed never reaches the all-zero lockup state.
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (state_q)
      S_IDLE: begin
        winner_d = 2'b00;
        foul_d   = 2'b00;
        rt_d     = '0;
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        winner_d = 2'b00;
        foul_d   = 2'b00;
        rt_d     = '0;
        // A button still held from the last round must be released before the wait starts.
        if (!p0_btn && !p1_btn) begin
          state_d = S_WAIT;
          cnt_d   = delay_load;
        end
      end
      S_WAIT: begin
        if (p0_press || p1_press) begin
          state_d = S_DONE;
          rv_d    = 1'b1;
          foul_d  = {p1_press, p0_press};
          // A lone fouler hands the round to the opponent; a double foul has no winner.
          case ({p1_press, p0_press})
            2'b01:   winner_d = 2'b10;
            2'b10:   winner_d = 2'b01;
            default: winner_d = 2'b00;
          endcase
        end else if (cnt_q <= ONE) begin
          state_d = S_DRAW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_DRAW: begin
        if (p0_press || p1_press) begin
          state_d  = S_DONE;
          rv_d     = 1'b1;
          winner_d = {p1_press, p0_press};
          foul_d   = 2'b00;
          rt_d     = cnt_q;
        end else if (cnt_q >= TO_LAST) begin
          state_d  = S_DONE;
          rv_d     = 1'b1;
          winner_d = 2'b00;
          foul_d   = 2'b00;
          rt_d     = TO_VAL;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + ONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d  = S_ARM;
          winner_d = 2'b00;
          foul_d   = 2'b00;
          rt_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ARM) || (state_d == S_WAIT) || (state_d == S_DRAW);
    draw_d = (state_d == S_DRAW);
  end

  // State and registered outputs; reset returns to IDLE immediately without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      p0_prev_q <= 1'b0;
      p1_prev_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      draw_q    <= 1'b0;
      rv_q      <= 1'b0;
      winner_q  <= 2'b00;
      foul_q    <= 2'b00;
      rt_q      <= '0;
    end else begin
      state_q   <= state_d;
      p0_prev_q <= p0_prev_d;
      p1_prev_q <= p1_prev_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      draw_q    <= draw_d;
      rv_q      <= rv_d;
      winner_q  <= winner_d;
      foul_q    <= foul_d;
      rt_q      <= rt_d;
    end
  end

  assign busy          = busy_q;
  assign draw          = draw_q;
  assign result_valid  = rv_q;
  assign winner        = winner_q;
  assign foul          = foul_q;
  assign reaction_time = rt_q;

endmodule

// File: doc/standoff_arbiter.md
# standoff_arbiter

Round controller for the two-player standoff game. Sits downstream of the keyboard debouncer and takes the two debounced player buttons as requesters for a single "first shot" resource. Each round it arms, waits a pseudo-random delay, raises the draw cue, and arbitrates which player pressed first. It reports fouls (early presses), ties, timeouts and the winner's reaction time to the display/score logic.

## Interface
Parameters:
- WAIT_MIN, default 100_000_000: minimum cycles from arm to draw cue.
- DELAY_SHIFT, default 19: random component is lfsr_snap[7:0] << DELAY_SHIFT cycles.
- TIMEOUT, default 300_000_000: draw-window length in cycles before the round ends with no winner.
- RT_W, default 32: width of reaction-time and delay counters.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; all state and outputs cleared immediately.
- start  in  1  level; sampled in IDLE/DONE to begin a round.
- p0_btn  in  1  debounced player-0 button (level, high = pressed).
- p1_btn  in  1  debounced player-1 button.
- busy  out  1  high in ARM, WAIT, DRAW.
- draw  out  1  draw cue; high exactly while in DRAW.
- result_valid  out  1  one-cycle pulse on entry to DONE.
- winner  out  2  00 none, 01 P0, 10 P1, 11 tie; held through DONE.
- foul  out  2  bit0 = P0 fouled, bit1 = P1 fouled; held through DONE.
- reaction_time  out  RT_W  DRAW cycles elapsed at winning press; held through DONE.

## Operation
- Edge detect: registered p0_prev/p1_prev; press = btn & ~prev. Only rising edges count as presses.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on reset, advances every cycle in every state (never all-zero).
- States:
  - IDLE: outputs zero. start=1 → ARM.
  - ARM: clears winner/foul/reaction_time. Waits until p0_btn=0 and p1_btn=0 (both levels), then → WAIT. Snapshots lfsr[7:0] and loads delay counter with WAIT_MIN + (snap << DELAY_SHIFT).
  - WAIT: delay counter decrements each cycle. Press by P0 only → foul=01, winner=10, → DONE. P1 only → foul=10, winner=01. Both same cycle → foul=11, winner=00. Counter reaching 0 with no press → DRAW.
  - DRAW: draw=1. Reaction counter starts at 0 on the first DRAW cycle and increments every cycle. P0 press only → winner=01; P1 only → winner=10; both same cycle → winner=11. reaction_time = counter value in the press cycle; → DONE. Counter reaching TIMEOUT-1 with no press → DONE, winner=00, foul=00, reaction_time=TIMEOUT.
  - DONE: results held. start=1 → ARM (new round); otherwise stay.
- start is ignored in ARM/WAIT/DRAW. Button held from a previous round gives no press edge; ARM blocks until release.
- Counters saturate rather than wrap; delay sum computed in RT_W bits, so parameters must fit.

## Timing
- Reset (async): state=IDLE, all outputs 0, prev regs 0, LFSR=16'hACE1.
- start sampled high in IDLE at cycle t → busy=1 at t+1.
- Both buttons low in ARM → WAIT next cycle. WAIT lasts exactly D = WAIT_MIN + (snap<<DELAY_SHIFT) cycles, then draw=1 on the next cycle.
- Press edge registered at cycle p (press comb true) → state DONE, draw=0 and result_valid=1 at p+1; outputs registered, one-cycle latency.
- result_valid is high for exactly one cycle per round, including fouls and timeouts.
- Reset mid-round: immediate return to IDLE, draw drops asynchronously, no result_valid.

## Test plan
- Normal P0 win (WAIT_MIN=10, DELAY_SHIFT=0, TIMEOUT=50): start, P0 rises at DRAW cycle 7 → winner=01, foul=00, reaction_time=7, single result_valid pulse.
- Early press: P1 rises during WAIT → winner=01, foul=10, draw never asserts.
- Tie and double foul: both rise same cycle in DRAW → winner=11; both rise same cycle in WAIT → winner=00, foul=11.
- Timeout: no press for 50 DRAW cycles → winner=00, foul=00, reaction_time=50, draw high exactly 50 cycles.
- Held button: P0 held high through start → stays in ARM with draw=0 until release, then WAIT; holding does not count as a press.
- Async reset during DRAW: reset pulse mid-cycle → draw=0 and busy=0 without a clock edge, LFSR=ACE1, next start yields identical delay to a fresh power-up.
